// File: rtl/riscv_dmem_ctrl_pkg.sv
// Shared constants for the data-memory controller: funct3 load/store encodings,
// FSM state encodings and the funct3 -> access-format decode.
package riscv_dmem_ctrl_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] FUNCT3_MEM_BYTE   = 3'b000;
    localparam logic [2:0] FUNCT3_MEM_HALF   = 3'b001;
    localparam logic [2:0] FUNCT3_MEM_WORD   = 3'b010;
    localparam logic [2:0] FUNCT3_MEM_DOUBLE = 3'b011;
    localparam logic [2:0] FUNCT3_MEM_BYTEU  = 3'b100;
    localparam logic [2:0] FUNCT3_MEM_HALFU  = 3'b101;
    localparam logic [2:0] FUNCT3_MEM_WORDU  = 3'b110;

    typedef enum logic [1:0] {
        DMEM_S_IDLE = 2'b00,
        DMEM_S_ACC0 = 2'b01,
        DMEM_S_ACC1 = 2'b10,
        DMEM_S_RESP = 2'b11
    } dmem_state_e;

    // lsz is log2 of the access size in bytes; sext selects sign extension of loads
    typedef struct packed {
        logic [1:0] lsz;
        logic       sext;
    } acc_fmt_t;

    function automatic acc_fmt_t decode_fmt(input logic [2:0] f3, input logic rv64);
        acc_fmt_t fmt;
        fmt.lsz  = rv64 ? 2'd3 : 2'd2;
        fmt.sext = 1'b0;
        case (f3)
            FUNCT3_MEM_BYTE:   begin fmt.lsz = 2'd0; fmt.sext = 1'b1; end
            FUNCT3_MEM_HALF:   begin fmt.lsz = 2'd1; fmt.sext = 1'b1; end
            FUNCT3_MEM_WORD:   begin fmt.lsz = 2'd2; fmt.sext = rv64; end
            FUNCT3_MEM_DOUBLE: if (rv64) fmt.lsz = 2'd3;
            FUNCT3_MEM_BYTEU:  fmt.lsz = 2'd0;
            FUNCT3_MEM_HALFU:  fmt.lsz = 2'd1;
            FUNCT3_MEM_WORDU:  if (rv64) fmt.lsz = 2'd2;
            default: ;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/riscv_dmem_lane_align.sv
// Combinational lane steering: byte strobes and shifted store data per beat, and
// load assembly/extension. o_split exists only with RISCV_DMEM_MISALIGN_EN.
module riscv_dmem_lane_align #(
    parameter int XLEN = 32
) (
    input  logic                        i_beat1,
    input  logic [1:0]                  i_lsz,
    input  logic                        i_sext,
    input  logic [$clog2(XLEN/8)-1:0]   i_off,
    input  logic [XLEN-1:0]             i_wr_data,
    input  logic [XLEN-1:0]             i_d0,
    input  logic [XLEN-1:0]             i_d1,
    output logic [XLEN/8-1:0]           o_byte_sel,
    output logic [XLEN-1:0]             o_wr_data,
    output logic [XLEN-1:0]             o_rd_data
`ifdef RISCV_DMEM_MISALIGN_EN
    ,
    output logic                        o_split
`endif
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam logic [OW:0] ONE_B = (OW+1)'(1);
    localparam logic [OW:0] NB_B  = (OW+1)'(NB);

    logic [OW:0]     size_b;
    logic [OW:0]     off_b;
    logic [OW:0]     rem_b;
    logic [OW+3:0]   nbits;
    logic [NB-1:0]   strb;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] sh;

    assign size_b = ONE_B << i_lsz;
    assign off_b  = {1'b0, i_off};
    assign rem_b  = NB_B - off_b;
    assign strb   = ~({NB{1'b1}} << size_b);

    assign o_byte_sel = i_beat1 ? (strb >> rem_b) : (strb << i_off);
    assign o_wr_data  = i_beat1 ? (i_wr_data >> {rem_b, 3'b000}) : (i_wr_data << {i_off, 3'b000});

    // d1 is zero for single-beat loads, so the OR only contributes on a split
    assign raw   = (i_d0 >> {i_off, 3'b000}) | (i_d1 << {rem_b, 3'b000});
    assign nbits = {size_b, 3'b000};
    assign keep  = ~({XLEN{1'b1}} << nbits);
    assign sh    = raw >> (nbits - 1'b1);
    assign o_rd_data = (raw & keep) | ((i_sext & sh[0]) ? ~keep : '0);

`ifdef RISCV_DMEM_MISALIGN_EN
    assign o_split = (off_b + size_b) > NB_B;
`endif

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Sequential MEM-stage data-memory controller with req/ack memory handshake.
// RISCV_DMEM_MISALIGN_EN: split word-crossing accesses instead of rejecting them.
module riscv_dmem_ctrl
    import riscv_dmem_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_wen,
    input  logic [2:0]        i_func3,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [XLEN-1:0]   o_rd_data,
    output logic              o_misalign_err,
    output logic              o_mem_req,
    output logic              o_mem_wen,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN-1:0]   o_mem_wr_data,
    output logic [XLEN/8-1:0] o_mem_byte_sel,
    input  logic              i_mem_ack,
    input  logic [XLEN-1:0]   i_mem_rd_data
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam logic [XLEN-1:0] BEAT_STEP = XLEN'(NB);

    dmem_state_e     state_q, state_d;
    logic [1:0]      lsz_q, lsz_d;
    logic            sext_q, sext_d;
    logic            wen_q, wen_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    acc_fmt_t        dec;
    logic            misal;
    logic            beat1;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] la_d0, la_d1;
    logic [XLEN-1:0] la_wdata, la_rdata;
    logic [NB-1:0]   la_sel;

    assign dec = decode_fmt(i_func3, XLEN == 64);

`ifdef RISCV_DMEM_MISALIGN_EN
    logic            split;
    logic [XLEN-1:0] d0_q, d0_d;

    assign misal = 1'b0;
    assign beat1 = (state_q == DMEM_S_ACC1);
    assign la_d0 = beat1 ? d0_q : i_mem_rd_data;
    assign la_d1 = beat1 ? i_mem_rd_data : '0;
    assign o_misalign_err = 1'b0;
`else
    logic [OW-1:0]   amask;
    logic            err_q, err_d;

    // offset must be a multiple of the access size
    assign amask = ~({OW{1'b1}} << dec.lsz);
    assign misal = |(i_addr[OW-1:0] & amask);
    assign beat1 = 1'b0;
    assign la_d0 = i_mem_rd_data;
    assign la_d1 = '0;
    assign o_misalign_err = (state_q == DMEM_S_RESP) & err_q;
`endif

    riscv_dmem_lane_align #(.XLEN(XLEN)) u_align (
        .i_beat1    (beat1),
        .i_lsz      (lsz_q),
        .i_sext     (sext_q),
        .i_off      (addr_q[OW-1:0]),
        .i_wr_data  (wdata_q),
        .i_d0       (la_d0),
        .i_d1       (la_d1),
        .o_byte_sel (la_sel),
        .o_wr_data  (la_wdata),
        .o_rd_data  (la_rdata)
`ifdef RISCV_DMEM_MISALIGN_EN
        ,
        .o_split    (split)
`endif
    );

    assign base           = {addr_q[XLEN-1:OW], {OW{1'b0}}};
    assign o_mem_req      = (state_q == DMEM_S_ACC0) | (state_q == DMEM_S_ACC1);
    assign o_mem_wen      = o_mem_req & wen_q;
    assign o_mem_addr     = o_mem_req ? (beat1 ? base + BEAT_STEP : base) : '0;
    assign o_mem_byte_sel = o_mem_req ? la_sel : '0;
    assign o_mem_wr_data  = o_mem_req ? la_wdata : '0;
    assign o_done         = (state_q == DMEM_S_RESP);
    assign o_busy         = ((state_q == DMEM_S_IDLE) & i_req) | o_mem_req;
    assign o_rd_data      = rdata_q;

    always_comb begin
        state_d = state_q;
        lsz_d   = lsz_q;
        sext_d  = sext_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef RISCV_DMEM_MISALIGN_EN
        d0_d    = d0_q;
`else
        err_d   = err_q;
`endif
        case (state_q)
            DMEM_S_IDLE: begin
                if (i_req) begin
                    lsz_d   = dec.lsz;
                    sext_d  = dec.sext;
                    wen_d   = i_wen;
                    addr_d  = i_addr;
                    wdata_d = i_wr_data;
`ifndef RISCV_DMEM_MISALIGN_EN
                    err_d   = misal;
`endif
                    state_d = misal ? DMEM_S_RESP : DMEM_S_ACC0;
                end
            end
            DMEM_S_ACC0: begin
                if (i_mem_ack) begin
`ifdef RISCV_DMEM_MISALIGN_EN
                    if (split) begin
                        d0_d    = i_mem_rd_data;
                        state_d = DMEM_S_ACC1;
                    end else begin
                        if (!wen_q) rdata_d = la_rdata;
                        state_d = DMEM_S_RESP;
                    end
`else
                    if (!wen_q) rdata_d = la_rdata;
                    state_d = DMEM_S_RESP;
`endif
                end
            end
`ifdef RISCV_DMEM_MISALIGN_EN
            DMEM_S_ACC1: begin
                if (i_mem_ack) begin
                    if (!wen_q) rdata_d = la_rdata;
                    state_d = DMEM_S_RESP;
                end
            end
`endif
            DMEM_S_RESP: state_d = DMEM_S_IDLE;
            default:     state_d = DMEM_S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= DMEM_S_IDLE;
            rdata_q <= '0;
`ifndef RISCV_DMEM_MISALIGN_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
`ifndef RISCV_DMEM_MISALIGN_EN
            err_q   <= err_d;
`endif
        end
    end

    // request context needs no reset: memory outputs are gated by o_mem_req
    always_ff @(posedge i_clk) begin
        lsz_q   <= lsz_d;
        sext_q  <= sext_d;
        wen_q   <= wen_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
`ifdef RISCV_DMEM_MISALIGN_EN
        d0_q    <= d0_d;
`endif
    end

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Bench for riscv_dmem_ctrl (XLEN=32): directed cases plus random accesses checked
// against a byte-addressed memory model; follows RISCV_DMEM_MISALIGN_EN if defined.
module tb_riscv_dmem_ctrl;
    localparam int XLEN = 32;
    localparam int NB   = 4;
    localparam int MSZ  = 64;

    logic        clk = 1'b0;
    logic        rst, req, wen;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        busy, done, merr;
    logic [31:0] rdata;
    logic        mreq, mwen, mack;
    logic [31:0] maddr, mwdata, mrdata;
    logic [3:0]  msel;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_dut [MSZ];
    logic [7:0]  mem_ref [MSZ];
    logic [31:0] exp_rd;
    int          nbeats, done_cyc;
    logic        got_done, got_err;
    logic [31:0] got_rd;
    logic [31:0] b_addr [2];
    logic [3:0]  b_sel  [2];
    logic [31:0] b_data [2];

    always #5 clk = ~clk;

    riscv_dmem_ctrl #(.XLEN(XLEN)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req          (req),
        .i_wen          (wen),
        .i_func3        (f3),
        .i_addr         (addr),
        .i_wr_data      (wdata),
        .o_busy         (busy),
        .o_done         (done),
        .o_rd_data      (rdata),
        .o_misalign_err (merr),
        .o_mem_req      (mreq),
        .o_mem_wen      (mwen),
        .o_mem_addr     (maddr),
        .o_mem_wr_data  (mwdata),
        .o_mem_byte_sel (msel),
        .i_mem_ack      (mack),
        .i_mem_rd_data  (mrdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int f3_size(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int midx(input logic [31:0] a, input int k);
        return (int'(a[5:0]) + k) % MSZ;
    endfunction

    // Drives one request and acts as the memory; records beats and completion.
    task automatic access(input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input int wt);
        int waited;
        waited   = 0;
        nbeats   = 0;
        got_done = 1'b0;
        got_err  = 1'b0;
        got_rd   = '0;
        done_cyc = -1;
        req = 1'b1; wen = w; f3 = f; addr = a; wdata = d;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (got_done) break;
            @(negedge clk);
            if (cyc == 0) begin
                chk("busy_accept", {31'b0, busy}, 32'd1);
                chk("done_idle", {31'b0, done}, 32'd0);
            end
            if (mreq && nbeats < 2) begin
                if (waited == 0) begin
                    b_addr[nbeats] = maddr;
                    b_sel[nbeats]  = msel;
                    b_data[nbeats] = mwdata;
                end else begin
                    chk("stable_addr", maddr, b_addr[nbeats]);
                    chk("stable_sel", {28'b0, msel}, {28'b0, b_sel[nbeats]});
                end
                if (waited == wt) begin
                    mack = 1'b1;
                    for (int j = 0; j < NB; j++) begin
                        mrdata[8*j +: 8] = mem_dut[midx(maddr, j)];
                        if (mwen && msel[j]) mem_dut[midx(maddr, j)] = mwdata[8*j +: 8];
                    end
                    nbeats++;
                    waited = 0;
                end else begin
                    waited++;
                end
            end else if (mreq) begin
                nbeats++;
                mack = 1'b1;
            end
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                got_rd   = rdata;
                got_err  = merr;
            end
            @(posedge clk);
            #1;
            req    = 1'b0;
            mack   = 1'b0;
            mrdata = $urandom;
        end
        chk("done_seen", {31'b0, got_done}, 32'd1);
    endtask

    // Runs an access and compares it with the byte-level reference.
    task automatic run_check(input logic w, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] d, input int wt);
        int sz, exp_beats, exp_lat;
        logic rej, sgn;
        logic [31:0] v;
        sz  = f3_size(f);
        sgn = (f == 3'b000) || (f == 3'b001);
`ifdef RISCV_DMEM_MISALIGN_EN
        rej       = 1'b0;
        exp_beats = (int'(a[1:0]) + sz > NB) ? 2 : 1;
`else
        rej       = (int'(a[1:0]) % sz) != 0;
        exp_beats = rej ? 0 : 1;
`endif
        exp_lat = rej ? 1 : 1 + exp_beats * (1 + wt);
        access(w, f, a, d, wt);
        if (!rej) begin
            if (w) begin
                for (int k = 0; k < sz; k++) mem_ref[midx(a, k)] = d[8*k +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < sz; k++) v[8*k +: 8] = mem_ref[midx(a, k)];
                if (sgn && v[8*sz-1]) for (int k = sz; k < NB; k++) v[8*k +: 8] = 8'hFF;
                exp_rd = v;
            end
        end
        chk("beats", 32'(nbeats), 32'(exp_beats));
        chk("latency", 32'(done_cyc), 32'(exp_lat));
        chk("misalign_err", {31'b0, got_err}, {31'b0, rej});
        chk("rd_data", got_rd, exp_rd);
    endtask

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra;
        int          rsz;
        rst = 1'b1; req = 1'b0; wen = 1'b0; f3 = 3'b000; addr = '0; wdata = '0;
        mack = 1'b0; mrdata = '0; exp_rd = '0;
        for (int i = 0; i < MSZ; i++) begin
            mem_dut[i] = 8'($urandom);
            mem_ref[i] = mem_dut[i];
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mem_req", {31'b0, mreq}, 32'd0);
        chk("rst_misalign", {31'b0, merr}, 32'd0);
        chk("rst_rd_data", rdata, 32'd0);
        chk("rst_mem_addr", maddr, 32'd0);
        chk("rst_mem_sel", {28'b0, msel}, 32'd0);
        @(posedge clk);
        #1;

        // SW, zero-wait ack
        run_check(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0);
        chk("sw_addr", b_addr[0], 32'h0000_0100);
        chk("sw_sel", {28'b0, b_sel[0]}, 32'hF);
        chk("sw_data", b_data[0], 32'hDEAD_BEEF);
        chk("sw_done_cyc", 32'(done_cyc), 32'd2);

        // LB / LBU of a memory word 0x80000000
        for (int k = 0; k < NB; k++) begin
            mem_dut[k] = (k == 3) ? 8'h80 : 8'h00;
            mem_ref[k] = mem_dut[k];
        end
        run_check(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0);
        chk("lb_value", got_rd, 32'hFFFF_FF80);
        run_check(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0);
        chk("lbu_value", got_rd, 32'h0000_0080);

`ifdef RISCV_DMEM_MISALIGN_EN
        run_check(1'b1, 3'b001, 32'h0000_0103, 32'h0000_ABCD, 0);
        chk("sh_b0_addr", b_addr[0], 32'h0000_0100);
        chk("sh_b0_sel", {28'b0, b_sel[0]}, 32'h8);
        chk("sh_b0_data", b_data[0], 32'hCD00_0000);
        chk("sh_b1_addr", b_addr[1], 32'h0000_0104);
        chk("sh_b1_sel", {28'b0, b_sel[1]}, 32'h1);
        chk("sh_b1_data", b_data[1], 32'h0000_00AB);
        chk("sh_done_cyc", 32'(done_cyc), 32'd3);
`else
        run_check(1'b0, 3'b010, 32'h0000_0102, 32'h0, 0);
        chk("lw_mis_beats", 32'(nbeats), 32'd0);
        chk("lw_mis_done_cyc", 32'(done_cyc), 32'd1);
        chk("lw_mis_err", {31'b0, got_err}, 32'd1);
        chk("lw_mis_rd_held", got_rd, 32'h0000_0080);
`endif

        // reset while ACC0 waits for ack
        req = 1'b1; wen = 1'b0; f3 = 3'b010; addr = 32'h0000_0108;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("rstmid_req_c1", {31'b0, mreq}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rstmid_req_c2", {31'b0, mreq}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_req_off", {31'b0, mreq}, 32'd0);
        chk("rstmid_no_done", {31'b0, done}, 32'd0);
        chk("rstmid_busy", {31'b0, busy}, 32'd0);
        chk("rstmid_rd", rdata, 32'd0);
        exp_rd = '0;
        @(posedge clk);
        #1;
        run_check(1'b0, 3'b010, 32'h0000_0108, 32'h0, 1);

        // random accesses
        for (int n = 0; n < 60; n++) begin
            rf  = 3'($urandom_range(0, 7));
            rsz = f3_size(rf);
            ra  = $urandom;
            if ($urandom_range(0, 1) == 1) ra = ra & ~(32'(rsz) - 32'd1);
            run_check(1'($urandom_range(0, 1)), rf, ra, $urandom, int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < MSZ; i++) chk("mem_contents", {24'b0, mem_dut[i]}, {24'b0, mem_ref[i]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
